// File: rtl/gpio_exp_pkg.sv
// Shared types and constants for the GPIO expander SPI front end.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package gpio_exp_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CMD,
        ST_WDATA,
        ST_APB_SETUP,
        ST_APB_ACCESS,
        ST_TURN,
        ST_RDATA,
        ST_DONE
    } state_e;

    // Command byte field positions
    localparam int CMD_W_BIT   = 7;
    localparam int CMD_BANK_HI = 6;
    localparam int CMD_BANK_LO = 5;
    localparam int CMD_ADDR_HI = 4;
    localparam int CMD_ADDR_LO = 2;

    localparam logic [1:0] BANK_NONE   = 2'd0;
    localparam logic [7:0] RD_ERR_DATA = 8'hFF;
    localparam logic [7:0] DUMMY_DATA  = 8'h00;

endpackage

// File: rtl/spi_sync_edge.sv
// Two-flop synchroniser for an asynchronous pin plus single-cycle rise/fall strobes.
// Latency: sync_o lags the pin by 2-3 pclk; strobes coincide with the sync_o change.
// Backpressure: none, free-running.
module spi_sync_edge #(
    parameter logic RST_VAL = 1'b0
) (
    input  logic pclk,
    input  logic presetn,
    input  logic din_i,
    output logic sync_o,
    output logic rise_o,
    output logic fall_o
);

    logic meta_q;
    logic sync_q;
    logic prev_q;

    // Metastability chain followed by one delay stage for edge detection
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
            prev_q <= RST_VAL;
        end else begin
            meta_q <= din_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign sync_o = sync_q;
    assign rise_o = sync_q & ~prev_q;
    assign fall_o = ~sync_q & prev_q;

endmodule

// File: rtl/spi_apb_bridge.sv
// SPI-slave (mode 0, MSB first) to APB-master bridge: one APB transfer per frame.
// Latency: APB setup 1 pclk after the byte-completing sclk strobe; access 1..TIMEOUT pclk.
// Backpressure: waits on pready up to TIMEOUT access cycles, then aborts with apb_err and 0xFF.
module spi_apb_bridge
    import gpio_exp_pkg::*;
#(
    parameter int TIMEOUT = 16
) (
    input  logic       pclk,
    input  logic       presetn,
    input  logic       sclk,
    input  logic       cs_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    output logic [2:0] paddr,
    output logic       pwrite,
    output logic [1:0] pselx,
    output logic       penable,
    output logic [7:0] pwdata,
    input  logic [7:0] prdata,
    input  logic       pready,
    output logic       apb_err
);

    localparam int TW = $clog2(TIMEOUT + 1);

    logic sclk_s, sclk_rise, sclk_fall;
    logic cs_s, cs_rise, cs_fall;
    logic mosi_s, mosi_rise, mosi_fall;
    logic unused_sync;

    // cs_n chain resets low so a frame already in progress at reset release
    // produces no falling edge until the pin has gone high first.
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_sclk (
        .pclk(pclk), .presetn(presetn), .din_i(sclk),
        .sync_o(sclk_s), .rise_o(sclk_rise), .fall_o(sclk_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_cs (
        .pclk(pclk), .presetn(presetn), .din_i(cs_n),
        .sync_o(cs_s), .rise_o(cs_rise), .fall_o(cs_fall));
    spi_sync_edge #(.RST_VAL(1'b0)) u_sync_mosi (
        .pclk(pclk), .presetn(presetn), .din_i(mosi),
        .sync_o(mosi_s), .rise_o(mosi_rise), .fall_o(mosi_fall));

    assign unused_sync = ^{sclk_s, cs_rise, mosi_rise, mosi_fall};

    state_e         state_q, state_d;
    logic [6:0]     shin_q, shin_d;
    logic [7:0]     shin_next;
    logic [7:0]     shout_q, shout_d;
    logic [7:0]     rdata_q, rdata_d;
    logic [2:0]     bit_cnt_q, bit_cnt_d;
    logic [TW-1:0]  tout_q, tout_d;
    logic [1:0]     bank_q, bank_d;
    logic [2:0]     addr_q, addr_d;
    logic           dummy_done_q, dummy_done_d;
    logic           abort_q, abort_d;
    logic           armed_q;
    logic [1:0]     pselx_q, pselx_d;
    logic [2:0]     paddr_q, paddr_d;
    logic           pwrite_q, pwrite_d;
    logic           penable_q, penable_d;
    logic [7:0]     pwdata_q, pwdata_d;
    logic           miso_q, miso_d;
    logic           apb_err_q, apb_err_d;
    logic           byte_done;
    logic           apb_done;

    assign shin_next = {shin_q, mosi_s};
    assign byte_done = sclk_rise && (bit_cnt_q == 3'd7);

    // State register
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // Datapath and registered APB/SPI outputs
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn) begin
            shin_q       <= '0;
            shout_q      <= '0;
            rdata_q      <= '0;
            bit_cnt_q    <= '0;
            tout_q       <= '0;
            bank_q       <= '0;
            addr_q       <= '0;
            dummy_done_q <= 1'b0;
            abort_q      <= 1'b0;
            pselx_q      <= '0;
            paddr_q      <= '0;
            pwrite_q     <= 1'b0;
            penable_q    <= 1'b0;
            pwdata_q     <= '0;
            miso_q       <= 1'b0;
            apb_err_q    <= 1'b0;
        end else begin
            shin_q       <= shin_d;
            shout_q      <= shout_d;
            rdata_q      <= rdata_d;
            bit_cnt_q    <= bit_cnt_d;
            tout_q       <= tout_d;
            bank_q       <= bank_d;
            addr_q       <= addr_d;
            dummy_done_q <= dummy_done_d;
            abort_q      <= abort_d;
            pselx_q      <= pselx_d;
            paddr_q      <= paddr_d;
            pwrite_q     <= pwrite_d;
            penable_q    <= penable_d;
            pwdata_q     <= pwdata_d;
            miso_q       <= miso_d;
            apb_err_q    <= apb_err_d;
        end
    end

    // MISO enable only once cs_n has been seen high since reset
    always_ff @(posedge pclk or negedge presetn) begin
        if (!presetn)  armed_q <= 1'b0;
        else if (cs_s) armed_q <= 1'b1;
    end

    // Frame sequencing, bit counting and APB handshake
    always_comb begin
        state_d      = state_q;
        shin_d       = shin_q;
        shout_d      = shout_q;
        rdata_d      = rdata_q;
        bit_cnt_d    = bit_cnt_q;
        tout_d       = tout_q;
        bank_d       = bank_q;
        addr_d       = addr_q;
        dummy_done_d = dummy_done_q;
        abort_d      = abort_q;
        pselx_d      = pselx_q;
        paddr_d      = paddr_q;
        pwrite_d     = pwrite_q;
        penable_d    = penable_q;
        pwdata_d     = pwdata_q;
        miso_d       = miso_q;
        apb_err_d    = 1'b0;
        apb_done     = 1'b0;

        // The bit counter keeps running through the APB phases so the dummy byte is tracked
        if (sclk_rise && state_q != ST_IDLE && state_q != ST_DONE) begin
            shin_d    = shin_next[6:0];
            bit_cnt_d = bit_cnt_q + 3'd1;
        end
        if (byte_done && (state_q == ST_APB_SETUP || state_q == ST_APB_ACCESS || state_q == ST_TURN))
            dummy_done_d = 1'b1;

        case (state_q)
            ST_IDLE: begin
                miso_d = 1'b0;
                if (cs_fall) begin
                    state_d      = ST_CMD;
                    bit_cnt_d    = 3'd0;
                    dummy_done_d = 1'b0;
                    abort_d      = 1'b0;
                end
            end
            ST_CMD: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end else if (byte_done) begin
                    bank_d = shin_next[CMD_BANK_HI:CMD_BANK_LO];
                    addr_d = shin_next[CMD_ADDR_HI:CMD_ADDR_LO];
                    if (shin_next[CMD_W_BIT]) begin
                        state_d = ST_WDATA;
                    end else if (shin_next[CMD_BANK_HI:CMD_BANK_LO] != BANK_NONE) begin
                        state_d  = ST_APB_SETUP;
                        pselx_d  = shin_next[CMD_BANK_HI:CMD_BANK_LO];
                        paddr_d  = shin_next[CMD_ADDR_HI:CMD_ADDR_LO];
                        pwrite_d = 1'b0;
                    end else begin
                        state_d = ST_TURN;
                        rdata_d = 8'h00;
                    end
                end
            end
            ST_WDATA: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end else if (byte_done) begin
                    if (bank_q != BANK_NONE) begin
                        state_d  = ST_APB_SETUP;
                        pselx_d  = bank_q;
                        paddr_d  = addr_q;
                        pwrite_d = 1'b1;
                        pwdata_d = shin_next;
                    end else begin
                        state_d = ST_DONE;
                    end
                end
            end
            ST_APB_SETUP: begin
                if (cs_s) abort_d = 1'b1;
                penable_d = 1'b1;
                tout_d    = '0;
                state_d   = ST_APB_ACCESS;
            end
            ST_APB_ACCESS: begin
                if (cs_s) abort_d = 1'b1;
                if (pready) begin
                    apb_done = 1'b1;
                    if (!pwrite_q) rdata_d = prdata;
                end else if (tout_q == TW'(TIMEOUT - 1)) begin
                    apb_done  = 1'b1;
                    apb_err_d = 1'b1;
                    rdata_d   = RD_ERR_DATA;
                end else begin
                    tout_d = tout_q + TW'(1);
                end
                if (apb_done) begin
                    pselx_d   = '0;
                    paddr_d   = '0;
                    pwrite_d  = 1'b0;
                    pwdata_d  = '0;
                    penable_d = 1'b0;
                    if (abort_q || cs_s) state_d = ST_IDLE;
                    else if (pwrite_q)   state_d = ST_DONE;
                    else                 state_d = ST_TURN;
                end
            end
            ST_TURN: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                end else if (dummy_done_q && sclk_fall) begin
                    miso_d  = rdata_q[7];
                    shout_d = {rdata_q[6:0], 1'b0};
                    state_d = ST_RDATA;
                end
            end
            ST_RDATA: begin
                if (cs_s) begin
                    state_d = ST_IDLE;
                    miso_d  = 1'b0;
                end else if (byte_done) begin
                    state_d = ST_DONE;
                    miso_d  = 1'b0;
                end else if (sclk_fall) begin
                    miso_d  = shout_q[7];
                    shout_d = {shout_q[6:0], 1'b0};
                end
            end
            ST_DONE: begin
                miso_d = 1'b0;
                if (cs_s) state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign miso    = miso_q;
    assign miso_oe = armed_q & ~cs_s;
    assign paddr   = paddr_q;
    assign pwrite  = pwrite_q;
    assign pselx   = pselx_q;
    assign penable = penable_q;
    assign pwdata  = pwdata_q;
    assign apb_err = apb_err_q;

endmodule

// File: tb/tb_spi_apb_bridge.sv
// Self-checking bench for spi_apb_bridge: SPI master driver, APB slave responder, reference model.
// Latency: n/a.
// Backpressure: slave pready delay programmable per frame; bank 2 never answers.
module tb_spi_apb_bridge;

    logic       pclk;
    logic       presetn;
    logic       sclk;
    logic       cs_n;
    logic       mosi;
    logic       miso;
    logic       miso_oe;
    logic [2:0] paddr;
    logic       pwrite;
    logic [1:0] pselx;
    logic       penable;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;
    logic       apb_err;

    spi_apb_bridge #(.TIMEOUT(16)) dut (
        .pclk(pclk), .presetn(presetn), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .paddr(paddr), .pwrite(pwrite),
        .pselx(pselx), .penable(penable), .pwdata(pwdata), .prdata(prdata),
        .pready(pready), .apb_err(apb_err));

    initial begin
        pclk = 1'b0;
        forever #5 pclk = ~pclk;
    end

    int checks = 0;
    int errors = 0;

    // Slave register files (written by the DUT) and the reference copy (written by the model)
    logic [7:0] smem    [4][8];
    logic [7:0] ref_mem [4][8];
    int         slave_del = 0;

    // Expectation for the frame currently on the wire
    bit         exp_xfer = 1'b0;
    bit         exp_timeout = 1'b0;
    bit         exp_write = 1'b0;
    logic [1:0] exp_bank = '0;
    logic [2:0] exp_addr = '0;
    logic [7:0] exp_wdata = '0;
    int         n_setup = 0;
    int         n_err = 0;
    logic [7:0] last_rd = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // APB slave: pready after slave_del access cycles; bank 2 has no slave
    initial begin
        int acc_k;
        acc_k  = 0;
        pready = 1'b0;
        prdata = 8'h00;
        forever begin
            @(negedge pclk);
            if (presetn && penable && pselx != 2'd0 && pselx != 2'd2) begin
                if (acc_k >= slave_del) begin
                    pready = 1'b1;
                    prdata = smem[pselx][paddr];
                    if (pwrite) smem[pselx][paddr] = pwdata;
                end else begin
                    pready = 1'b0;
                    prdata = 8'($urandom);
                end
                acc_k++;
            end else begin
                acc_k  = 0;
                pready = 1'b0;
                prdata = 8'($urandom);
            end
        end
    end

    // Per-cycle compare against the expected transaction
    initial begin
        int   cs_stable;
        int   pen_age;
        bit   armed_tb;
        logic cs_prev, pen_prev;
        logic [1:0] psel_prev;
        cs_stable = 0; pen_age = 0; armed_tb = 1'b0;
        cs_prev = 1'b1; pen_prev = 1'b0; psel_prev = '0;
        forever begin
            @(negedge pclk);
            if (!presetn) begin
                armed_tb = 1'b0; cs_stable = 0; pen_prev = 1'b0; psel_prev = '0;
                continue;
            end
            if (cs_n === cs_prev) cs_stable++;
            else                  cs_stable = 0;
            cs_prev = cs_n;
            if (cs_n) armed_tb = 1'b1;
            if (armed_tb && cs_stable >= 4) chk("miso_oe", miso_oe, !cs_n);
            if (cs_n && cs_stable >= 4)     chk("miso_idle", miso, 0);
            if (pselx == 2'd0) begin
                chk("pen_nosel", penable, 0);
                chk("paddr_idle", paddr, 0);
                chk("pwrite_idle", pwrite, 0);
                chk("pwdata_idle", pwdata, 0);
            end else if (!exp_xfer) begin
                chk("psel_unexpected", pselx, 0);
            end else begin
                chk("pselx", pselx, exp_bank);
                chk("paddr", paddr, exp_addr);
                chk("pwrite", pwrite, exp_write);
                if (exp_write) chk("pwdata", pwdata, exp_wdata);
                if (psel_prev == 2'd0) begin
                    n_setup++;
                    chk("setup_penable", penable, 0);
                end else begin
                    chk("access_penable", penable, 1);
                end
            end
            if (penable && !pen_prev) pen_age = 0;
            else                      pen_age++;
            if (apb_err) begin
                n_err++;
                chk("err_delay", pen_age, 16);
                chk("err_penable", penable, 0);
            end
            pen_prev  = penable;
            psel_prev = pselx;
        end
    end

    // Mode-0 SPI master: data set while sclk low, sampled at rising edge
    task automatic spi_xfer(input logic [23:0] tx, input int nbits, input int h,
                            output logic [23:0] rx);
        rx   = '0;
        cs_n = 1'b0;
        for (int i = 0; i < nbits; i++) begin
            mosi = tx[23-i];
            #h;
            sclk = 1'b1;
            rx[23-i] = miso;
            #h;
            sclk = 1'b0;
        end
        #h;
        cs_n = 1'b1;
        mosi = 1'b0;
    endtask

    task automatic run_frame(input logic [7:0] c, input logic [7:0] d, input int nbits);
        logic [23:0] rx;
        logic [7:0]  exp_rd;
        bit          w, full;
        logic [1:0]  b;
        logic [2:0]  a;
        w = c[7]; b = c[6:5]; a = c[4:2];
        full        = w ? (nbits >= 16) : (nbits >= 8);
        exp_bank    = b;
        exp_addr    = a;
        exp_write   = w;
        exp_wdata   = d;
        exp_xfer    = full && (b != 2'd0);
        exp_timeout = exp_xfer && (b == 2'd2);
        exp_rd      = (b == 2'd0) ? 8'h00 : (b == 2'd2) ? 8'hFF : ref_mem[b][a];
        n_setup = 0;
        n_err   = 0;
        @(negedge pclk);
        spi_xfer({c, d, 8'h00}, nbits, 10 * $urandom_range(4, 7), rx);
        repeat (40) @(negedge pclk);
        chk("xfer_count", n_setup, exp_xfer);
        chk("err_count", n_err, exp_timeout);
        if (!w && nbits == 24) begin
            chk("rd_dummy", rx[15:8], 8'h00);
            chk("rd_data", rx[7:0], exp_rd);
            last_rd = rx[7:0];
        end
        if (exp_xfer && w && b != 2'd2) ref_mem[b][a] = d;
        exp_xfer = 1'b0;
    endtask

    initial begin
        #3ms;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "bench did not complete");
    end

    initial begin
        logic [23:0] rx_r;
        logic [7:0]  c, d;
        int          nb, len, k;
        for (int bb = 0; bb < 4; bb++)
            for (int aa = 0; aa < 8; aa++) begin
                smem[bb][aa]    = 8'($urandom);
                ref_mem[bb][aa] = smem[bb][aa];
            end
        presetn = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
        repeat (3) @(negedge pclk);
        chk("rst_miso", miso, 0);
        chk("rst_miso_oe", miso_oe, 0);
        chk("rst_paddr", paddr, 0);
        chk("rst_pwrite", pwrite, 0);
        chk("rst_pselx", pselx, 0);
        chk("rst_penable", penable, 0);
        chk("rst_pwdata", pwdata, 0);
        chk("rst_apb_err", apb_err, 0);
        presetn = 1'b1;
        repeat (10) @(negedge pclk);

        // Write bank 1 addr 3 data 0x5A
        slave_del = 2;
        run_frame(8'hAC, 8'h5A, 16);
        chk("wr_bank1_a3", smem[1][3], 8'h5A);

        // Read bank 1 addr 4 holding 0xC3, pready delay 3
        smem[1][4] = 8'hC3; ref_mem[1][4] = 8'hC3;
        slave_del = 3;
        run_frame(8'h30, 8'h00, 24);
        chk("rd_bank1_a4", last_rd, 8'hC3);

        // pready on the last allowed access cycle still succeeds
        slave_del = 15;
        run_frame(8'h30, 8'h00, 24);
        chk("rd_late_ready", last_rd, 8'hC3);

        // Bank 0 write and read
        run_frame(8'h8C, 8'h11, 16);
        run_frame(8'h0C, 8'h00, 24);
        chk("rd_bank0", last_rd, 8'h00);

        // Bank 2 has no slave: timeout
        run_frame(8'h44, 8'h00, 24);
        chk("rd_timeout_data", last_rd, 8'hFF);
        chk("rd_timeout_pulses", n_err, 1);

        // Truncated write then a full one
        smem[3][2] = 8'h00; ref_mem[3][2] = 8'h00;
        slave_del = 1;
        run_frame(8'hE8, 8'h77, 12);
        chk("trunc_no_write", smem[3][2], 8'h00);
        run_frame(8'hE8, 8'h77, 16);
        chk("full_after_trunc", smem[3][2], 8'h77);

        // Reset during APB access
        exp_bank = 2'd2; exp_addr = 3'd1; exp_write = 1'b0;
        exp_xfer = 1'b1; exp_timeout = 1'b1;
        n_err = 0;
        k = 0;
        @(negedge pclk);
        fork
            spi_xfer({8'h44, 8'h00, 8'h00}, 24, 50, rx_r);
            begin
                while (!penable && k < 400) begin
                    @(negedge pclk);
                    k++;
                end
                chk("rst_reach_access", penable, 1);
                @(negedge pclk);
                @(negedge pclk);
                #2;
                exp_xfer = 1'b0;
                exp_timeout = 1'b0;
                presetn = 1'b0;
                #1;
                chk("rst_async_penable", penable, 0);
                chk("rst_async_pselx", pselx, 0);
                chk("rst_async_miso", miso, 0);
                repeat (3) @(negedge pclk);
                presetn = 1'b1;
            end
        join
        repeat (40) @(negedge pclk);
        chk("rst_no_err", n_err, 0);
        slave_del = 0;
        run_frame(8'hF4, 8'h3C, 16);
        chk("post_rst_write", smem[3][5], 8'h3C);

        // Randomized frames, some truncated
        for (int f = 0; f < 40; f++) begin
            c   = 8'($urandom);
            d   = 8'($urandom);
            len = c[7] ? 16 : 24;
            nb  = ($urandom_range(0, 4) == 0) ? int'($urandom_range(1, len - 1)) : len;
            slave_del = $urandom_range(0, 6);
            run_frame(c, d, nb);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
